// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared FSM encoding and sweep-length helper for the truth table sweeper
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_DWELL  = 20;
    localparam int DEF_SETTLE = 2;

    // Number of input combinations swept for an n-input DUT.
    function automatic int vecs_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_timer.sv
// truth_table_sweeper_dwell_timer: per-vector dwell counter with settle and end-of-dwell strobes
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   clear     in   restart the count at zero
//   en        in   count this cycle (strobes are only raised while enabled)
//   at_settle out  count == SETTLE, the sample point of the current vector
//   at_end    out  count == DWELL-1, last cycle of the current vector
module truth_table_sweeper_dwell_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int DWELL  = DEF_DWELL,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic at_settle,
    output logic at_end
);

    localparam int CW = $clog2(DWELL);

    logic [CW-1:0] cnt;

    always_comb begin
        at_settle = en && (cnt == CW'(SETTLE));
        at_end    = en && (cnt == CW'(DWELL - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (en)
            cnt <= at_end ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input combination to a combinational DUT and captures its truth table
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   one-cycle sweep request (ignored while a sweep runs)
//   f_in      in   DUT output under test
//   abcd      out  DUT input vector, MSB = A
//   busy      out  sweep in progress
//   done      out  table complete, held until the next accepted start or reset
//   table_out out  bit i = f_in captured while abcd == i
//   ones_cnt  out  number of ones in table_out
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int DWELL  = DEF_DWELL,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    f_in,
    output logic [N_IN-1:0]         abcd,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<N_IN)-1:0]    table_out,
    output logic [N_IN:0]           ones_cnt
);

    localparam int VECS = vecs_of(N_IN);

    state_t          state, state_nx;
    logic [N_IN-1:0] vec;
    logic            accept, last_vec, at_settle, at_end;

    truth_table_sweeper_dwell_timer #(
        .DWELL  (DWELL),
        .SETTLE (SETTLE)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .en        (state == DRIVE),
        .at_settle (at_settle),
        .at_end    (at_end)
    );

    always_comb begin
        accept   = start && (state != DRIVE);
        last_vec = (vec == N_IN'(VECS - 1));
        state_nx = state;
        if (accept)
            state_nx = DRIVE;
        else if (state == DRIVE && at_end && last_vec)
            state_nx = DONE;
    end

    // busy/done decode straight from the state register, so they can never both be high.
    always_comb begin
        busy = (state == DRIVE);
        done = (state == DONE);
        abcd = vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            table_out <= '0;
            ones_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                vec       <= '0;
                table_out <= '0;
                ones_cnt  <= '0;
            end else if (state == DRIVE) begin
                if (at_settle) begin
                    table_out[vec] <= f_in;
                    ones_cnt       <= ones_cnt + (N_IN+1)'(f_in);
                end
                // On the last vector vec stays at VECS-1 and the FSM moves to DONE.
                if (at_end && !last_vec)
                    vec <= vec + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int N_IN   = 4;
    localparam int DWELL  = 20;
    localparam int SETTLE = 2;
    localparam int SWEEP  = 16 * DWELL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        f_in = 1'b0;
    logic [3:0]  abcd;
    logic        busy, done;
    logic [15:0] table_out;
    logic [4:0]  ones_cnt;

    int errors = 0;
    int checks = 0;

    truth_table_sweeper #(
        .N_IN   (N_IN),
        .DWELL  (DWELL),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .f_in      (f_in),
        .abcd      (abcd),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .ones_cnt  (ones_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          mode;
        bit          glitch;
        int          restart_at;
        int          abort_at;
        logic [15:0] exp_tbl;
        logic [4:0]  exp_ones;
    } sweep_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference DUT functions: 0 parity, 1 AND, 2 constant 0, 3 NOT A.
    function automatic logic fn(input int mode, input int v);
        logic [3:0] x;
        x = v[3:0];
        case (mode)
            0:       return ^x;
            1:       return &x;
            3:       return ~x[3];
            default: return 1'b0;
        endcase
    endfunction

    // Cycle t (1..SWEEP) is the cycle before the t-th edge after the accepting edge;
    // in it the DUT must hold vector (t-1)/DWELL and samples only at phase SETTLE.
    task automatic sweep(input sweep_t s);
        int v, ph, bad_abcd, bad_flags;
        bad_abcd  = 0;
        bad_flags = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("accept_clear", {done, busy, ones_cnt, table_out}, {1'b0, 1'b1, 5'd0, 16'd0});
        for (int t = 1; t <= SWEEP; t++) begin
            v  = (t - 1) / DWELL;
            ph = (t - 1) % DWELL;
            if (abcd !== v[3:0]) bad_abcd++;
            if (busy !== 1'b1 || done !== 1'b0) bad_flags++;
            f_in  = fn(s.mode, v) ^ (s.glitch && ph != SETTLE);
            start = (t == s.restart_at);
            if (t == s.abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                start = 1'b0;
                check("abort_abcd_seq", bad_abcd, 0);
                check("reset_mid_sweep", {abcd, busy, done, table_out, ones_cnt}, 0);
                repeat (3) @(posedge clk);
                #1 check("reset_stays_idle", {abcd, busy, done}, 0);
                return;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("abcd_sequence", bad_abcd, 0);
        check("busy_during_sweep", bad_flags, 0);
        check("done_at_latency", {done, busy}, 2'b10);
        check("table_out", table_out, s.exp_tbl);
        check("ones_cnt", ones_cnt, s.exp_ones);
        check("abcd_final", abcd, 4'hF);
        f_in = ~f_in;
        repeat (5) @(posedge clk);
        #1 check("done_hold", {done, busy, abcd, table_out, ones_cnt}, {2'b10, 4'hF, s.exp_tbl, s.exp_ones});
    endtask

    initial begin
        sweep_t vecs[7];
        vecs[0] = '{0, 1'b0, 0,   0,   16'h6996, 5'd8};
        vecs[1] = '{1, 1'b0, 0,   0,   16'h8000, 5'd1};
        vecs[2] = '{2, 1'b0, 0,   0,   16'h0000, 5'd0};
        vecs[3] = '{3, 1'b0, 0,   0,   16'h00FF, 5'd8};
        vecs[4] = '{0, 1'b1, 0,   0,   16'h6996, 5'd8};
        vecs[5] = '{1, 1'b0, 100, 0,   16'h8000, 5'd1};
        vecs[6] = '{3, 1'b1, 0,   150, 16'h0000, 5'd0};

        repeat (2) @(posedge clk);
        #1 check("reset_state", {abcd, busy, done, table_out, ones_cnt}, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("idle_without_start", {abcd, busy, done}, 0);

        for (int i = 0; i < 7; i++) sweep(vecs[i]);

        sweep(vecs[3]);

        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 check("reset_beats_start", {abcd, busy, done, table_out, ones_cnt}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        sweep(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
